// File: rtl/adc_spi_pkg.sv
// Shared constants, FSM state type and helpers for the ADC serial-port responder.
package adc_spi_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 11;
    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 5;

    // bit_cnt value for a complete frame, and the saturation value marking overflow
    localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
    localparam logic [CNT_W-1:0] CNT_MAX  = 5'd17;

    // Register 0 control bit positions
    localparam int PDN_BIT  = 0;
    localparam int RST_BIT  = 4;
    localparam int GAIN_BIT = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Bit counter increment that sticks at CNT_MAX so long frames stay flagged
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return cnt + 5'd1;
        end
    endfunction

endpackage

// File: rtl/adc_spi_responder_sync.sv
// Input synchronizer and edge detector for the serial port pins.
// All three pins go through the same depth so that SDATA stays aligned with
// the SCLK/SEN edges derived here. Reset values keep SCLK idle-high and SEN
// low, so a frame already running at reset release never shows a SEN fall.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sclk_in,
    input  logic sdata_in,
    input  logic sen_in,
    output logic sdata_sync,
    output logic sclk_fall,
    output logic sen_fall,
    output logic sen_rise
);

    logic [SYNC_STAGES-1:0] sclk_pipe_r;
    logic [SYNC_STAGES-1:0] sdata_pipe_r;
    logic [SYNC_STAGES-1:0] sen_pipe_r;
    logic                   sclk_prev_r;
    logic                   sen_prev_r;
    logic                   sclk_sync_s;
    logic                   sen_sync_s;

    // Synchronizer chains plus one extra flop per clock/enable for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_pipe_r  <= '1;
            sdata_pipe_r <= '0;
            sen_pipe_r   <= '0;
            sclk_prev_r  <= 1'b1;
            sen_prev_r   <= 1'b0;
        end else begin
            sclk_pipe_r  <= {sclk_pipe_r[SYNC_STAGES-2:0], sclk_in};
            sdata_pipe_r <= {sdata_pipe_r[SYNC_STAGES-2:0], sdata_in};
            sen_pipe_r   <= {sen_pipe_r[SYNC_STAGES-2:0], sen_in};
            sclk_prev_r  <= sclk_sync_s;
            sen_prev_r   <= sen_sync_s;
        end
    end

    assign sclk_sync_s = sclk_pipe_r[SYNC_STAGES-1];
    assign sen_sync_s  = sen_pipe_r[SYNC_STAGES-1];
    assign sdata_sync  = sdata_pipe_r[SYNC_STAGES-1];

    assign sclk_fall = sclk_prev_r & ~sclk_sync_s;
    assign sen_fall  = sen_prev_r & ~sen_sync_s;
    assign sen_rise  = ~sen_prev_r & sen_sync_s;

endmodule

// File: rtl/adc_spi_responder.sv
// Serial-port responder: collects 16-bit write frames (5-bit address, 11-bit
// data, MSB first), keeps a 32 x 11 register image and decodes the reg0
// control bits (soft reset, power-down, coarse gain).
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              SDATA,
    input  logic              SEN,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              soft_reset,
    output logic              power_down,
    output logic              coarse_gain
);

    logic                  sdata_sync_s;
    logic                  sclk_fall_s;
    logic                  sen_fall_s;
    logic                  sen_rise_s;

    state_t                state_r;
    state_t                next_state_s;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_eff_s;
    logic [FRAME_BITS-1:0] shift_eff_s;
    logic                  frame_err_s;
    logic                  commit_s;
    logic                  clear_all_s;
    logic [ADDR_W-1:0]     frame_addr_s;
    logic [DATA_W-1:0]     frame_data_s;

    logic [DATA_W-1:0]     regs_r [NUM_REGS];
    logic [DATA_W-1:0]     rd_data_r;
    logic                  wr_strobe_r;
    logic [ADDR_W-1:0]     wr_addr_r;
    logic [DATA_W-1:0]     wr_data_r;
    logic                  frame_err_r;
    logic                  soft_reset_r;
    logic                  power_down_r;
    logic                  coarse_gain_r;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock      (clock),
        .reset      (reset),
        .sclk_in    (SCLK),
        .sdata_in   (SDATA),
        .sen_in     (SEN),
        .sdata_sync (sdata_sync_s),
        .sclk_fall  (sclk_fall_s),
        .sen_fall   (sen_fall_s),
        .sen_rise   (sen_rise_s)
    );

    assign frame_addr_s = shift_r[FRAME_BITS-1 -: ADDR_W];
    assign frame_data_s = shift_r[DATA_W-1:0];
    assign clear_all_s  = (frame_addr_s == {ADDR_W{1'b0}}) && frame_data_s[RST_BIT];

    // Counter/shift values including this cycle's bit, so a SEN rise in the
    // same cycle as the last SCLK fall sees the complete frame length
    always_comb begin
        cnt_eff_s   = bit_cnt_r;
        shift_eff_s = shift_r;
        if (sclk_fall_s) begin
            cnt_eff_s   = cnt_sat_inc(bit_cnt_r);
            shift_eff_s = {shift_r[FRAME_BITS-2:0], sdata_sync_s};
        end else begin
            cnt_eff_s   = bit_cnt_r;
            shift_eff_s = shift_r;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (sen_fall_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (sen_rise_s) begin
                    if (cnt_eff_s == CNT_FULL) begin
                        next_state_s = COMMIT;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = SHIFT;
                end
            end
            COMMIT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: frame error on a wrong-length frame, commit for one cycle
    always_comb begin
        frame_err_s = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            SHIFT: begin
                if (sen_rise_s && (cnt_eff_s != CNT_FULL)) begin
                    frame_err_s = 1'b1;
                end else begin
                    frame_err_s = 1'b0;
                end
            end
            COMMIT:  commit_s = 1'b1;
            default: begin
                frame_err_s = 1'b0;
                commit_s    = 1'b0;
            end
        endcase
    end

    // Bit counter and shift register: cleared on frame start, loaded while shifting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sen_fall_s) begin
                        bit_cnt_r <= 5'd0;
                        shift_r   <= 16'h0000;
                    end
                end
                SHIFT: begin
                    bit_cnt_r <= cnt_eff_s;
                    shift_r   <= shift_eff_s;
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                    shift_r   <= shift_r;
                end
            endcase
        end
    end

    // Register image: a reg0 write with the reset bit set clears every register
    // and is itself not stored
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 11'h000;
            end
        end else if (commit_s) begin
            if (clear_all_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    regs_r[i] <= 11'h000;
                end
            end else begin
                regs_r[frame_addr_s] <= frame_data_s;
            end
        end
    end

    // Registered outputs: commit report, error pulse, reg0 decode and read port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_strobe_r   <= 1'b0;
            wr_addr_r     <= 5'd0;
            wr_data_r     <= 11'h000;
            frame_err_r   <= 1'b0;
            soft_reset_r  <= 1'b0;
            power_down_r  <= 1'b0;
            coarse_gain_r <= 1'b0;
            rd_data_r     <= 11'h000;
        end else begin
            wr_strobe_r   <= commit_s;
            frame_err_r   <= frame_err_s;
            soft_reset_r  <= commit_s && clear_all_s;
            power_down_r  <= regs_r[0][PDN_BIT];
            coarse_gain_r <= regs_r[0][GAIN_BIT];
            rd_data_r     <= regs_r[rd_addr];
            if (commit_s) begin
                wr_addr_r <= frame_addr_s;
                wr_data_r <= frame_data_s;
            end
        end
    end

    assign rd_data     = rd_data_r;
    assign wr_strobe   = wr_strobe_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign frame_err   = frame_err_r;
    assign soft_reset  = soft_reset_r;
    assign power_down  = power_down_r;
    assign coarse_gain = coarse_gain_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Table-driven bench for adc_spi_responder, plus hand sequences for
// mid-frame reset and read-during-commit.
module tb_adc_spi_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        SCLK  = 1'b1;
    logic        SDATA = 1'b0;
    logic        SEN   = 1'b1;
    logic [4:0]  rd_addr = 5'd0;
    logic [10:0] rd_data;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [10:0] wr_data;
    logic        frame_err;
    logic        soft_reset;
    logic        power_down;
    logic        coarse_gain;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .SCLK        (SCLK),
        .SDATA       (SDATA),
        .SEN         (SEN),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .soft_reset  (soft_reset),
        .power_down  (power_down),
        .coarse_gain (coarse_gain)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Pulse counters, sampled on the falling clock edge
    int strobe_cnt = 0;
    int err_cnt    = 0;
    int srst_cnt   = 0;

    always @(negedge clock) begin
        if (wr_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (soft_reset === 1'b1) srst_cnt = srst_cnt + 1;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [10:0] data;
        int          nbits;
        int          exp_strobe;
        int          exp_err;
        int          exp_srst;
        logic        exp_pdn;
        logic        exp_gain;
        logic [4:0]  rd_a;
        logic [10:0] rd_exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_frame();
        SEN  = 1'b0;
        SCLK = 1'b1;
        cyc(2);
    endtask

    // One bit at the master's native rate: SCLK high 2 cycles, low 1 cycle
    task automatic send_bit(input logic b);
        SDATA = b;
        SCLK  = 1'b1;
        cyc(2);
        SCLK  = 1'b0;
        cyc(1);
        SCLK  = 1'b1;
    endtask

    task automatic end_frame();
        cyc(2);
        SEN = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w, input int nbits);
        start_frame();
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) send_bit(w[15-i]);
            else        send_bit(1'b0);
        end
        end_frame();
    endtask

    initial begin
        int          s0, e0, r0;
        int          lat;
        logic [4:0]  exp_wa;
        logic [10:0] exp_wd;
        logic [15:0] w;

        //                addr   data    nb  stb err srst pdn   gain  rd_a   rd_exp
        vecs[0] = '{5'h0A, 11'h2AA, 16, 1, 0, 0, 1'b0, 1'b0, 5'h0A, 11'h2AA};
        vecs[1] = '{5'h00, 11'h200, 16, 1, 0, 0, 1'b0, 1'b1, 5'h00, 11'h200};
        vecs[2] = '{5'h00, 11'h001, 16, 1, 0, 0, 1'b1, 1'b0, 5'h00, 11'h001};
        vecs[3] = '{5'h00, 11'h010, 16, 1, 0, 1, 1'b0, 1'b0, 5'h0A, 11'h000};
        vecs[4] = '{5'h01, 11'h000, 16, 1, 0, 0, 1'b0, 1'b0, 5'h00, 11'h000};
        vecs[5] = '{5'h1F, 11'h7FF, 16, 1, 0, 0, 1'b0, 1'b0, 5'h1F, 11'h7FF};
        vecs[6] = '{5'h1F, 11'h000, 12, 0, 1, 0, 1'b0, 1'b0, 5'h1F, 11'h7FF};
        vecs[7] = '{5'h1F, 11'h000, 17, 0, 1, 0, 1'b0, 1'b0, 5'h1F, 11'h7FF};
        vecs[8] = '{5'h00, 11'h201, 16, 1, 0, 0, 1'b1, 1'b1, 5'h00, 11'h201};

        exp_wa = 5'h00;
        exp_wd = 11'h000;

        // Reset state
        cyc(3);
        reset = 1'b1;
        cyc(3);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_wr_addr", wr_addr, 5'h00);
        check("rst_wr_data", wr_data, 11'h000);
        check("rst_power_down", power_down, 1'b0);
        check("rst_coarse_gain", coarse_gain, 1'b0);
        check("rst_rd_data", rd_data, 11'h000);
        check("rst_pulses", strobe_cnt + err_cnt + srst_cnt, 0);

        // Table of frames
        for (int k = 0; k < 9; k++) begin
            s0 = strobe_cnt;
            e0 = err_cnt;
            r0 = srst_cnt;
            rd_addr = vecs[k].rd_a;
            send_word({vecs[k].addr, vecs[k].data}, vecs[k].nbits);
            cyc(8);
            if (vecs[k].exp_strobe != 0) begin
                exp_wa = vecs[k].addr;
                exp_wd = vecs[k].data;
            end
            check($sformatf("v%0d_strobes", k), strobe_cnt - s0, vecs[k].exp_strobe);
            check($sformatf("v%0d_errs", k), err_cnt - e0, vecs[k].exp_err);
            check($sformatf("v%0d_soft_resets", k), srst_cnt - r0, vecs[k].exp_srst);
            check($sformatf("v%0d_wr_addr", k), wr_addr, exp_wa);
            check($sformatf("v%0d_wr_data", k), wr_data, exp_wd);
            check($sformatf("v%0d_power_down", k), power_down, vecs[k].exp_pdn);
            check($sformatf("v%0d_coarse_gain", k), coarse_gain, vecs[k].exp_gain);
            check($sformatf("v%0d_rd_data", k), rd_data, vecs[k].rd_exp);
        end

        // Reset after 8 bits, released while SEN still low: rest of frame ignored
        w = {5'h04, 11'h155};
        rd_addr = 5'h04;
        s0 = strobe_cnt;
        e0 = err_cnt;
        start_frame();
        for (int i = 0; i < 8; i++) send_bit(w[15-i]);
        reset = 1'b0;
        cyc(2);
        check("midrst_power_down", power_down, 1'b0);
        check("midrst_wr_addr", wr_addr, 5'h00);
        reset = 1'b1;
        cyc(2);
        for (int i = 8; i < 16; i++) send_bit(w[15-i]);
        end_frame();
        cyc(8);
        check("midrst_strobes", strobe_cnt - s0, 0);
        check("midrst_errs", err_cnt - e0, 0);
        check("midrst_rd_data", rd_data, 11'h000);

        // Next full frame commits normally
        s0 = strobe_cnt;
        send_word(w, 16);
        cyc(8);
        check("after_rst_strobes", strobe_cnt - s0, 1);
        check("after_rst_wr_addr", wr_addr, 5'h04);
        check("after_rst_wr_data", wr_data, 11'h155);
        check("after_rst_rd_data", rd_data, 11'h155);

        // Read during commit to the same address returns the old value
        rd_addr = 5'h0C;
        w = {5'h0C, 11'h3FF};
        cyc(2);
        check("rdc_before", rd_data, 11'h000);
        start_frame();
        for (int i = 0; i < 16; i++) send_bit(w[15-i]);
        end_frame();
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (wr_strobe === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("rdc_strobe_latency", lat, 4);
        check("rdc_commit_cycle", rd_data, 11'h000);
        cyc(1);
        check("rdc_next_cycle", rd_data, 11'h3FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
